gb_camera_capture: RTL and testbench

- Sensor-side capture engine for the Game Boy Camera cartridge.
- The mapper exposes the CAM register window to the CPU. This block is the other end of that window.
- Owns the CAM register file. Runs the capture sequence: exposure wait, pixel fetch, 4x4 dither quantisation.
- Writes the resulting 2bpp tile image into cart RAM bank 0 at offset 0x0100, where the CPU later reads it through the mapper.

---
 rtl/gb_camera_capture_pkg.sv | 34 +++
 rtl/gb_camera_dither.sv | 25 ++
 rtl/gb_camera_capture.sv | 166 ++++++++++++++++
 tb/tb_gb_camera_capture.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_camera_capture_pkg.sv
// ============================================================================
// Module   : gb_camera_capture_pkg
// Brief    : Shared state encoding, CAM register indices and image constants
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gb_camera_capture_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXPOSE = 3'd1,
    S_FETCH  = 3'd2,
    S_QUANT  = 3'd3,
    S_WR_LO  = 3'd4,
    S_WR_HI  = 3'd5
  } cam_state_t;

  localparam logic [6:0]  CAM_REG_CTRL     = 7'd0;
  localparam logic [6:0]  CAM_REG_EXPO_H   = 7'd2;
  localparam logic [6:0]  CAM_REG_EXPO_L   = 7'd3;
  localparam logic [7:0]  CAM_MTX_BASE     = 8'd6;
  localparam logic [7:0]  CAM_MTX_LAST     = 8'h35;
  localparam int          CAM_NREGS        = 54;
  localparam logic [12:0] IMG_BASE_DEFAULT = 13'h0100;

  // First of the three thresholds for a pixel's 4x4 dither cell.
  function automatic logic [5:0] mtx_base(input logic [1:0] y, input logic [1:0] x);
    return CAM_MTX_BASE[5:0] + 6'({y, x}) * 6'd3;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gb_camera_dither.sv
// ============================================================================
// Module   : gb_camera_dither
// Brief    : Stateless 2-bit quantiser of one grey pixel against three thresholds
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gb_camera_dither (
  input  logic [7:0] pix,
  input  logic [7:0] t0,
  input  logic [7:0] t1,
  input  logic [7:0] t2,
  output logic [1:0] v
);

  always_comb begin
    v = 2'd0;
    if (pix < t0)      v = 2'd3;
    else if (pix < t1) v = 2'd2;
    else if (pix < t2) v = 2'd1;
  end

endmodule

`default_nettype wire

// File: rtl/gb_camera_capture.sv
// ============================================================================
// Module   : gb_camera_capture
// Brief    : CAM register file and capture sequencer producing a 2bpp tile image
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gb_camera_capture
  import gb_camera_capture_pkg::*;
#(
  parameter logic [12:0] IMG_BASE = IMG_BASE_DEFAULT,
  parameter int          TILES_X  = 16,
  parameter int          TILES_Y  = 14
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_cpu,
  input  logic        enable,
  input  logic        cam_wr,
  input  logic [6:0]  cam_addr,
  input  logic [7:0]  cam_di,
  output logic [7:0]  cam_do,
  output logic        busy,
  output logic        pix_req,
  output logic [6:0]  pix_x,
  output logic [6:0]  pix_y,
  input  logic        pix_ack,
  input  logic [7:0]  pix_data,
  output logic        cram_wr,
  output logic [16:0] cram_waddr,
  output logic [7:0]  cram_wdata,
  input  logic        cram_ack
);

  logic [7:0]  r_regs [0:CAM_NREGS-1];
  cam_state_t  r_state, w_state_next;
  logic [19:0] r_expo;
  logic [3:0]  r_tx, r_ty;
  logic [2:0]  r_r, r_c;
  logic [7:0]  r_pix, r_lo, r_hi;
  logic        r_pix_req, r_abort;

  logic        w_rst, w_ctrl_wr, w_reg_wr, w_start, w_stop, w_aborting, w_last, w_to_idle;
  logic [5:0]  w_mbase;
  logic [1:0]  w_v;
  logic [12:0] w_addr;

  assign w_rst      = reset | ~enable;
  assign w_ctrl_wr  = ce_cpu & cam_wr & (cam_addr == CAM_REG_CTRL);
  assign w_reg_wr   = ce_cpu & cam_wr & ({1'b0, cam_addr} <= CAM_MTX_LAST);
  assign w_start    = w_ctrl_wr & cam_di[0];
  assign w_stop     = w_ctrl_wr & ~cam_di[0];
  assign w_aborting = r_abort | w_stop;
  assign w_last     = (r_ty == 4'(TILES_Y - 1)) && (r_tx == 4'(TILES_X - 1)) && (r_r == 3'd7);
  assign w_to_idle  = (r_state != S_IDLE) && (w_state_next == S_IDLE);
  assign w_mbase    = mtx_base(r_r[1:0], r_c[1:0]);
  assign w_addr     = IMG_BASE + 13'({r_ty, r_tx, r_r, 1'b0});

  gb_camera_dither u_dither (
    .pix (r_pix),
    .t0  (r_regs[w_mbase]),
    .t1  (r_regs[w_mbase + 6'd1]),
    .t2  (r_regs[w_mbase + 6'd2]),
    .v   (w_v)
  );

  // An abort only waits while a handshake is actually outstanding.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_state_next = S_EXPOSE;
      S_EXPOSE: begin
        if (w_stop)                w_state_next = S_IDLE;
        else if (r_expo == 20'd0)  w_state_next = S_FETCH;
      end
      S_FETCH: begin
        if (r_pix_req) begin
          if (pix_ack) w_state_next = w_aborting ? S_IDLE : S_QUANT;
        end else if (w_aborting) begin
          w_state_next = S_IDLE;
        end
      end
      S_QUANT: begin
        if (w_stop)               w_state_next = S_IDLE;
        else if (r_c == 3'd7)     w_state_next = S_WR_LO;
        else                      w_state_next = S_FETCH;
      end
      S_WR_LO:  if (cram_ack) w_state_next = w_aborting ? S_IDLE : S_WR_HI;
      S_WR_HI:  if (cram_ack) w_state_next = (w_aborting || w_last) ? S_IDLE : S_FETCH;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (w_rst) begin
      r_state   <= S_IDLE;
      r_abort   <= 1'b0;
      r_expo    <= 20'd0;
      r_tx      <= 4'd0;
      r_ty      <= 4'd0;
      r_r       <= 3'd0;
      r_c       <= 3'd0;
      r_pix     <= 8'd0;
      r_lo      <= 8'd0;
      r_hi      <= 8'd0;
      r_pix_req <= 1'b0;
      for (int i = 0; i < CAM_NREGS; i++) r_regs[i] <= 8'h00;
    end else begin
      r_state <= w_state_next;
      r_abort <= w_aborting && (w_state_next != S_IDLE);

      if (w_reg_wr) r_regs[cam_addr[5:0]] <= cam_di;
      // A CPU write to the control register in the same cycle takes priority.
      if (w_to_idle && !w_ctrl_wr) r_regs[0][0] <= 1'b0;

      if (r_state == S_IDLE && w_start)
        r_expo <= {r_regs[CAM_REG_EXPO_H[5:0]], r_regs[CAM_REG_EXPO_L[5:0]], 4'h0};
      else if (r_state == S_EXPOSE && ce_cpu && r_expo != 20'd0)
        r_expo <= r_expo - 20'd1;

      if (w_state_next != S_FETCH)  r_pix_req <= 1'b0;
      else if (r_state == S_FETCH)  r_pix_req <= 1'b1;

      if (r_state == S_FETCH && r_pix_req && pix_ack) r_pix <= pix_data;

      if (r_state == S_EXPOSE) begin
        r_tx <= 4'd0;
        r_ty <= 4'd0;
        r_r  <= 3'd0;
        r_c  <= 3'd0;
      end

      if (r_state == S_QUANT) begin
        r_lo <= {r_lo[6:0], w_v[0]};
        r_hi <= {r_hi[6:0], w_v[1]};
        if (r_c != 3'd7) r_c <= r_c + 3'd1;
      end

      if (r_state == S_WR_HI && cram_ack && !w_aborting && !w_last) begin
        r_c <= 3'd0;
        r_r <= r_r + 3'd1;
        if (r_r == 3'd7) begin
          if (r_tx == 4'(TILES_X - 1)) begin
            r_tx <= 4'd0;
            r_ty <= r_ty + 4'd1;
          end else begin
            r_tx <= r_tx + 4'd1;
          end
        end
      end
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign cam_do     = (cam_addr == CAM_REG_CTRL) ? {r_regs[0][7:1], busy} : 8'h00;
  assign pix_req    = r_pix_req;
  assign pix_x      = {r_tx, r_c};
  assign pix_y      = {r_ty, r_r};
  assign cram_wr    = (r_state == S_WR_LO) || (r_state == S_WR_HI);
  assign cram_waddr = cram_wr ? {4'b0, w_addr + 13'(r_state == S_WR_HI)} : 17'd0;
  assign cram_wdata = (r_state == S_WR_LO) ? r_lo :
                      (r_state == S_WR_HI) ? r_hi : 8'h00;

endmodule

`default_nettype wire

// File: tb/tb_gb_camera_capture.sv
// ============================================================================
// Module   : tb_gb_camera_capture
// Brief    : Directed self-checking bench with pixel source and cart RAM sink
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gb_camera_capture;

  logic        clk_sys = 1'b0;
  logic        reset, ce_cpu, enable, cam_wr;
  logic [6:0]  cam_addr;
  logic [7:0]  cam_di, cam_do;
  logic        busy, pix_req, pix_ack, cram_wr, cram_ack;
  logic [6:0]  pix_x, pix_y;
  logic [7:0]  pix_data, cram_wdata;
  logic [16:0] cram_waddr;

  int          total = 0;
  int          bad   = 0;
  int          wr_count = 0;
  logic [12:0] exp_addr = 13'h0100;
  int          mode = 0;
  logic [7:0]  exp_lo = 8'hFF, exp_hi = 8'hFF, pix_val = 8'h00;
  bit          rnd_lat = 1'b0, c_hold = 1'b0;
  int          pwait = 0, cwait = 0;

  gb_camera_capture dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ce_cpu     (ce_cpu),
    .enable     (enable),
    .cam_wr     (cam_wr),
    .cam_addr   (cam_addr),
    .cam_di     (cam_di),
    .cam_do     (cam_do),
    .busy       (busy),
    .pix_req    (pix_req),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_ack    (pix_ack),
    .pix_data   (pix_data),
    .cram_wr    (cram_wr),
    .cram_waddr (cram_waddr),
    .cram_wdata (cram_wdata),
    .cram_ack   (cram_ack)
  );

  initial forever #5 clk_sys = ~clk_sys;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 20) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Columns 1 and 5 share matrix column x&3==1, so rows with y&3==0 lose bits 6 and 2.
  function automatic logic [7:0] exp_byte(input logic [12:0] a);
    logic [12:0] off;
    off = a - 13'h0100;
    if (mode == 1) return (off[2:1] == 2'b00) ? 8'hBB : 8'hFF;
    return off[0] ? exp_hi : exp_lo;
  endfunction

  // Pixel source and RAM sink; every accepted write is checked against the next expected address.
  initial begin
    pix_ack = 1'b0; cram_ack = 1'b0; pix_data = 8'h00;
    forever begin
      @(negedge clk_sys);
      pix_ack  = 1'b0;
      cram_ack = 1'b0;
      pix_data = pix_val;
      if (pix_req) begin
        if (pwait == 0) begin
          pix_ack = 1'b1;
          pwait = rnd_lat ? int'($urandom_range(7, 0)) : 0;
        end else pwait--;
      end
      if (cram_wr && !c_hold) begin
        if (cwait == 0) begin
          cram_ack = 1'b1;
          chk_eq("wr_addr", 32'(cram_waddr), 32'({4'b0, exp_addr}));
          chk_eq("wr_data", 32'(cram_wdata), 32'(exp_byte(exp_addr)));
          exp_addr++;
          wr_count++;
          cwait = rnd_lat ? int'($urandom_range(7, 0)) : 0;
        end else cwait--;
      end
    end
  end

  task automatic cam_write(input logic [6:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    cam_addr = a; cam_di = d; cam_wr = 1'b1; ce_cpu = 1'b1;
    @(negedge clk_sys);
    cam_wr = 1'b0;
  endtask

  task automatic cam_read(input logic [6:0] a, output logic [7:0] d);
    @(negedge clk_sys);
    cam_addr = a;
    #1 d = cam_do;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk_sys); n++; end
    chk_eq(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_writes(input int target, input int budget, input string tag);
    int n = 0;
    while (wr_count < target && n < budget) begin @(negedge clk_sys); n++; end
    chk_eq(tag, 32'(wr_count >= target), 32'd1);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int seen, n, cyc, wc0;
    reset = 1'b1; enable = 1'b1; ce_cpu = 1'b1; cam_wr = 1'b0;
    cam_addr = 7'd0; cam_di = 8'd0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;

    // Reset state and quiet idle
    cam_read(7'd0, d);
    chk_eq("rst_cam_do", 32'(d), 32'h00);
    chk_eq("rst_busy", 32'(busy), 32'd0);
    chk_eq("rst_waddr", 32'(cram_waddr), 32'd0);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_sys);
      if (pix_req || cram_wr) seen++;
    end
    chk_eq("idle_quiet", 32'(seen), 32'd0);

    // Full capture: exposure 2 (32 ticks), black pixels -> every byte 0xFF
    cam_write(7'd2, 8'h00);
    cam_write(7'd3, 8'h02);
    for (int i = 6; i < 54; i++)
      cam_write(7'(i), (i % 3 == 0) ? 8'h40 : (i % 3 == 1) ? 8'h80 : 8'hC0);
    cam_read(7'd3, d);
    chk_eq("rd_nonctrl", 32'(d), 32'h00);
    mode = 0; exp_lo = 8'hFF; exp_hi = 8'hFF; pix_val = 8'h00;
    wr_count = 0; exp_addr = 13'h0100;
    cam_write(7'd0, 8'h01);
    chk_eq("busy_start", 32'(busy), 32'd1);
    n = 0;
    for (cyc = 0; cyc < 1000 && !pix_req; cyc++) begin
      ce_cpu = (cyc % 4 == 0);
      @(posedge clk_sys);
      if (ce_cpu) n++;
      @(negedge clk_sys);
    end
    ce_cpu = 1'b1;
    chk_eq("expo_ticks", 32'(n), 32'd32);
    chk_eq("expo_cycles", 32'(cyc), 32'd127);
    wait_idle(60000, "full_done");
    chk_eq("full_count", 32'(wr_count), 32'd3584);
    chk_eq("full_end", 32'(exp_addr), 32'h0F00);
    cam_read(7'd0, d);
    chk_eq("full_ctrl", 32'(d), 32'h00);

    // Pixel 0x90 -> v=1; restart attempt while busy is ignored
    cam_write(7'd2, 8'h00);
    cam_write(7'd3, 8'h00);
    pix_val = 8'h90; exp_lo = 8'hFF; exp_hi = 8'h00;
    wr_count = 0; exp_addr = 13'h0100;
    cam_write(7'd0, 8'h01);
    wait_writes(2, 500, "p90_first");
    cam_write(7'd0, 8'h03);
    cam_read(7'd0, d);
    chk_eq("busy_rewrite", 32'(d), 32'h03);
    wait_writes(6, 500, "p90_more");
    cam_write(7'd0, 8'h00);
    wait_idle(200, "p90_abort");

    // Zeroed cell at x&3==1,y&3==0, random handshake latency
    cam_write(7'd9, 8'h00);
    cam_write(7'd10, 8'h00);
    cam_write(7'd11, 8'h00);
    mode = 1; pix_val = 8'h30; rnd_lat = 1'b1;
    wr_count = 0; exp_addr = 13'h0100;
    cam_write(7'd0, 8'h01);
    wait_writes(40, 8000, "cell_writes");
    cam_write(7'd0, 8'h00);
    wait_idle(200, "cell_abort");
    rnd_lat = 1'b0; mode = 0;
    cam_write(7'd9, 8'h40);
    cam_write(7'd10, 8'h80);
    cam_write(7'd11, 8'hC0);

    // Abort while a RAM write is pending: it completes, then idle
    pix_val = 8'h00; exp_lo = 8'hFF; exp_hi = 8'hFF;
    c_hold = 1'b1;
    wr_count = 0; exp_addr = 13'h0100;
    cam_write(7'd0, 8'h01);
    n = 0;
    while (!cram_wr && n < 300) begin @(negedge clk_sys); n++; end
    chk_eq("hold_wr_seen", 32'(cram_wr), 32'd1);
    wc0 = wr_count;
    cam_write(7'd0, 8'h00);
    repeat (3) @(negedge clk_sys);
    chk_eq("hold_busy", 32'(busy), 32'd1);
    chk_eq("hold_wr", 32'(cram_wr), 32'd1);
    c_hold = 1'b0;
    wait_idle(50, "hold_idle");
    chk_eq("hold_one_wr", 32'(wr_count - wc0), 32'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_sys);
      if (pix_req || cram_wr) seen++;
    end
    chk_eq("hold_quiet", 32'(seen), 32'd0);

    // Reset mid-capture clears every output in one cycle
    wr_count = 0; exp_addr = 13'h0100;
    cam_write(7'd0, 8'h01);
    wait_writes(4, 500, "rst_mid_run");
    @(negedge clk_sys);
    reset = 1'b1;
    cam_addr = 7'd0;
    @(negedge clk_sys);
    chk_eq("rst_mid_busy", 32'(busy), 32'd0);
    chk_eq("rst_mid_req", 32'(pix_req), 32'd0);
    chk_eq("rst_mid_wr", 32'(cram_wr), 32'd0);
    chk_eq("rst_mid_waddr", 32'(cram_waddr), 32'd0);
    chk_eq("rst_mid_wdata", 32'(cram_wdata), 32'd0);
    chk_eq("rst_mid_pix", 32'({pix_x, pix_y}), 32'd0);
    chk_eq("rst_mid_do", 32'(cam_do), 32'd0);
    reset = 1'b0;

    // enable low clears the register file
    cam_write(7'd0, 8'hA4);
    cam_read(7'd0, d);
    chk_eq("ctrl_stored", 32'(d), 32'hA4);
    @(negedge clk_sys);
    enable = 1'b0;
    @(negedge clk_sys);
    enable = 1'b1;
    cam_read(7'd0, d);
    chk_eq("enable_clear", 32'(d), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
